// File: rtl/apb_master_n_if.sv
// Signal bundle for apb_master_n: internal request side plus the N-slave APB side.
// The master modport is the apb_master_n view; slave is the environment view.
interface apb_master_n_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                      transfer;
  logic                      write;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wdata;
  logic                      ready;
  logic [DATA_W-1:0]         rdata;
  logic                      error;
  logic                      busy;
  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic                      PENABLE;
  logic [DATA_W-1:0]         PWDATA;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
    output ready, rdata, error, busy, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
    input  ready, rdata, error, busy, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );
endinterface

// File: rtl/apb_master_n.sv
// APB master with N-slave address decode, PSLVERR / decode-error / PREADY-timeout reporting.
// Optional one-deep command buffer enabled by defining APB_CMD_BUF_EN.
//
// state  | meaning
// IDLE   | no command in flight
// SETUP  | APB setup phase, PSEL asserted, PENABLE low
// ACCESS | APB access phase, waiting for PREADY or watchdog expiry
// DERR   | address hit no slave, error reported without bus activity
module apb_master_n #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter logic [ADDR_W-1:0] SLV_BASE  = 32'h1000_0000,
  parameter int                SLV_SHIFT = 12,
  parameter int                TIMEOUT   = 16
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_master_n_if.master bus
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DERR = 2'd3} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_write;
  logic [DATA_W-1:0] cur_wdata;
  logic [IDX_W-1:0]  cur_idx;
  logic [TMR_W-1:0]  tmr;
  logic              ready_q, error_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] in_off;
  logic              in_hit;
  logic [IDX_W-1:0]  in_idx;

  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              tmr_tc, done_ok, done_to, done;

  logic              launch, l_hit, l_write;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [IDX_W-1:0]  l_idx;

  logic [NUM_SLV-1:0] psel;
  logic               penable, busy;

`ifdef APB_CMD_BUF_EN
  logic              buf_vld, buf_write, buf_hit;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [IDX_W-1:0]  buf_idx;
  logic              launch_buf, capture;
`endif

  always_comb begin
    in_off = bus.addr - SLV_BASE;
    in_hit = (bus.addr >= SLV_BASE) && ((in_off >> SLV_SHIFT) < ADDR_W'(NUM_SLV));
    in_idx = in_off[SLV_SHIFT +: IDX_W];
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        sel_ready = bus.PREADY[i];
        sel_err   = bus.PSLVERR[i];
        sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // PREADY wins over watchdog expiry when both land in the same cycle
  always_comb begin
    tmr_tc  = (tmr == '0);
    done_ok = (state == ACCESS) && sel_ready;
    done_to = (TIMEOUT > 0) && (state == ACCESS) && !sel_ready && tmr_tc;
    done    = done_ok || done_to || (state == DERR);
  end

  always_comb begin
`ifdef APB_CMD_BUF_EN
    launch_buf = done && buf_vld;
    launch     = launch_buf || (bus.transfer && ((state == IDLE) || (done && !buf_vld)));
    capture    = bus.transfer && (state != IDLE) && !done && !buf_vld;
    l_hit      = launch_buf ? buf_hit   : in_hit;
    l_write    = launch_buf ? buf_write : bus.write;
    l_addr     = launch_buf ? buf_addr  : bus.addr;
    l_wdata    = launch_buf ? buf_wdata : bus.wdata;
    l_idx      = launch_buf ? buf_idx   : in_idx;
`else
    launch  = bus.transfer && (state == IDLE);
    l_hit   = in_hit;
    l_write = bus.write;
    l_addr  = bus.addr;
    l_wdata = bus.wdata;
    l_idx   = in_idx;
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (launch) state_nxt = l_hit ? SETUP : DERR;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (done) state_nxt = launch ? (l_hit ? SETUP : DERR) : IDLE;
      DERR:   state_nxt = launch ? (l_hit ? SETUP : DERR) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel    = '0;
    penable = (state == ACCESS);
    if ((state == SETUP) || (state == ACCESS)) begin
      for (int i = 0; i < NUM_SLV; i++) psel[i] = (cur_idx == IDX_W'(i));
    end
`ifdef APB_CMD_BUF_EN
    busy = buf_vld;
`else
    busy = (state != IDLE);
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cur_addr  <= '0;
      cur_write <= 1'b0;
      cur_wdata <= '0;
      cur_idx   <= '0;
      tmr       <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (launch) begin
        cur_addr  <= l_addr;
        cur_write <= l_write;
        cur_wdata <= l_wdata;
        cur_idx   <= l_idx;
      end
      if (state == SETUP)                                tmr <= TMR_LOAD;
      else if ((state == ACCESS) && !sel_ready && !tmr_tc) tmr <= tmr - 1'b1;
      ready_q <= done;
      error_q <= done_to || (state == DERR) || (done_ok && sel_err);
      if (done && !cur_write) rdata_q <= (done_ok && !sel_err) ? sel_rdata : '0;
    end
  end

`ifdef APB_CMD_BUF_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      buf_vld   <= 1'b0;
      buf_write <= 1'b0;
      buf_hit   <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      buf_idx   <= '0;
    end else if (capture) begin
      buf_vld   <= 1'b1;
      buf_write <= bus.write;
      buf_hit   <= in_hit;
      buf_addr  <= bus.addr;
      buf_wdata <= bus.wdata;
      buf_idx   <= in_idx;
    end else if (launch_buf) begin
      buf_vld <= 1'b0;
    end
  end
`endif

  assign bus.ready   = ready_q;
  assign bus.error   = error_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy;
  assign bus.PADDR   = cur_addr;
  assign bus.PWRITE  = cur_write;
  assign bus.PWDATA  = cur_wdata;
  assign bus.PSEL    = psel;
  assign bus.PENABLE = penable;

endmodule

// File: tb/tb_apb_master_n.sv
// Bench for apb_master_n: directed and random transfers against memory-backed slave models,
// with expected latency/error/rdata taken from an address-map and slave-memory reference.
module tb_apb_master_n;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 4;
  localparam int          SH   = 12;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0;
  int   errors = 0;

  apb_master_n_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

  apb_master_n #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS),
    .SLV_BASE(BASE), .SLV_SHIFT(SH), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  bit [31:0]   slv_mem [NS][16];
  bit [31:0]   ref_mem [NS][16];
  int          wait_cfg = 0;
  bit          err_cfg  = 1'b0;
  int          acc_cnt  = 0;
  bit [NS-1:0] noise_rdy, noise_err;
  bit [31:0]   noise_dat;
  logic [31:0] exp_rdata;

  always @(negedge PCLK) begin
    noise_rdy <= NS'($urandom);
    noise_err <= NS'($urandom);
    noise_dat <= $urandom;
  end

  // selected slave answers after wait_cfg ACCESS cycles; unselected slaves drive noise
  always_comb begin
    bus.PREADY  = '0;
    bus.PSLVERR = '0;
    bus.PRDATA  = '0;
    for (int i = 0; i < NS; i++) begin
      if (bus.PSEL[i]) begin
        bus.PREADY[i]            = bus.PENABLE && (acc_cnt >= wait_cfg);
        bus.PSLVERR[i]           = err_cfg;
        bus.PRDATA[i*DW +: DW]   = slv_mem[i][bus.PADDR[5:2]];
      end else begin
        bus.PREADY[i]            = noise_rdy[i];
        bus.PSLVERR[i]           = noise_err[i];
        bus.PRDATA[i*DW +: DW]   = noise_dat ^ 32'(i);
      end
    end
  end

  always @(posedge PCLK) begin
    if (!bus.PENABLE)                      acc_cnt <= 0;
    else if ((bus.PREADY & bus.PSEL) == '0) acc_cnt <= acc_cnt + 1;
    for (int i = 0; i < NS; i++)
      if (bus.PSEL[i] && bus.PENABLE && bus.PREADY[i] && bus.PWRITE && !err_cfg)
        slv_mem[i][bus.PADDR[5:2]] <= bus.PWDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hit(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> SH) < NS);
  endfunction

  task automatic xfer(input string tag, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input int waits, input bit serr);
    bit          hit, timed_out, exp_err;
    int          idx, exp_lat, lat, seq_bad, pen_cnt;
    logic [NS-1:0] exp_psel;
    hit       = ref_hit(a);
    idx       = hit ? int'((a - BASE) >> SH) : 0;
    timed_out = hit && (waits >= TO);
    exp_lat   = !hit ? 1 : (timed_out ? TO + 1 : waits + 2);
    exp_err   = !hit || timed_out || serr;
    exp_psel  = hit ? (NS'(1) << idx) : '0;
    wait_cfg  = waits;
    err_cfg   = serr;
    @(negedge PCLK);
    bus.transfer = 1'b1;
    bus.write    = wr;
    bus.addr     = a;
    bus.wdata    = wd;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    if (hit) begin
      chk({tag, ".paddr"}, bus.PADDR, a);
      chk({tag, ".pwrite"}, 32'(bus.PWRITE), 32'(wr));
      chk({tag, ".pwdata"}, bus.PWDATA, wd);
    end
`ifndef APB_CMD_BUF_EN
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
`endif
    lat = -1; seq_bad = 0; pen_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.ready) begin
        lat = k;
        break;
      end
      if (bus.PSEL !== exp_psel) seq_bad++;
      if (bus.PENABLE !== (hit && (k > 0))) seq_bad++;
      if (bus.PENABLE) pen_cnt++;
      @(negedge PCLK);
    end
    if (!wr) exp_rdata = exp_err ? 32'h0 : ref_mem[idx][a[5:2]];
    else if (!exp_err) ref_mem[idx][a[5:2]] = wd;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".error"}, 32'(bus.error), 32'(exp_err));
    chk({tag, ".rdata"}, bus.rdata, exp_rdata);
    chk({tag, ".psel_seq"}, 32'(seq_bad), 32'd0);
    chk({tag, ".penable_cycles"}, 32'(pen_cnt), hit ? 32'(exp_lat - 1) : 32'd0);
    @(negedge PCLK);
    chk({tag, ".ready_pulse"}, 32'(bus.ready), 32'd0);
    chk({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
    err_cfg = 1'b0;
  endtask

  int          r, waits, lat, nrdy;
  bit          serr, got;
  logic [31:0] a;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET       = 1'b1;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    exp_rdata    = '0;
    repeat (3) @(negedge PCLK);
    chk("rst.ready", 32'(bus.ready), 32'd0);
    chk("rst.error", 32'(bus.error), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    chk("rst.psel", 32'(bus.PSEL), 32'd0);
    chk("rst.penable", 32'(bus.PENABLE), 32'd0);
    chk("rst.paddr", bus.PADDR, 32'd0);
    chk("rst.pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst.pwdata", bus.PWDATA, 32'd0);
    PRESET = 1'b0;

    xfer("wr_s0", 1'b1, BASE, 32'd10, 0, 1'b0);
    xfer("wr_s1", 1'b1, BASE + 32'h1000, 32'd11, 0, 1'b0);
    xfer("wr_s2", 1'b1, BASE + 32'h2000, 32'd12, 0, 1'b0);
    xfer("rd_s0", 1'b0, BASE, 32'd0, 0, 1'b0);
    chk("rd_s0.value", bus.rdata, 32'h0000_000A);
    xfer("wr_s2_beef", 1'b1, BASE + 32'h2000, 32'hDEAD_BEEF, 0, 1'b0);
    xfer("rd_s2_wait3", 1'b0, BASE + 32'h2000, 32'd0, 3, 1'b0);
    xfer("rd_miss", 1'b0, 32'h2000_0000, 32'd0, 0, 1'b0);
    xfer("wr_below_base", 1'b1, BASE - 32'd4, 32'h77, 0, 1'b0);
    xfer("rd_above_map", 1'b0, BASE + 32'h4000, 32'd0, 0, 1'b0);
    xfer("wr_last_word", 1'b1, BASE + 32'h3FFC, 32'h55, 0, 1'b0);
    xfer("rd_last_word", 1'b0, BASE + 32'h3FFC, 32'd0, 1, 1'b0);
    xfer("rd_timeout", 0, BASE + 32'h1000, 32'd0, 40, 1'b0);
    xfer("rd_wait_to_m1", 1'b0, BASE + 32'h1000, 32'd0, TO - 1, 1'b0);
    xfer("wr_wait_to_eq", 1'b1, BASE + 32'h1004, 32'h99, TO, 1'b0);
    xfer("rd_after_to_wr", 1'b0, BASE + 32'h1004, 32'd0, 0, 1'b0);
    xfer("rd_slverr", 1'b0, BASE + 32'h1000, 32'd0, 1, 1'b1);
    xfer("wr_slverr", 1'b1, BASE + 32'h2000, 32'h1234, 0, 1'b1);
    xfer("rd_after_slverr", 1'b0, BASE + 32'h2000, 32'd0, 0, 1'b0);

    // reset in the middle of an ACCESS phase
    wait_cfg = 100;
    @(negedge PCLK);
    bus.transfer = 1'b1;
    bus.write    = 1'b0;
    bus.addr     = BASE + 32'h1000;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("midrst.pre_penable", 32'(bus.PENABLE), 32'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("midrst.psel", 32'(bus.PSEL), 32'd0);
    chk("midrst.penable", 32'(bus.PENABLE), 32'd0);
    chk("midrst.ready", 32'(bus.ready), 32'd0);
    chk("midrst.rdata", bus.rdata, 32'd0);
    exp_rdata = '0;
    got = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET   = 1'b0;
    wait_cfg = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (bus.ready) got = 1'b1;
    end
    chk("midrst.no_ready", 32'(got), 32'd0);
    xfer("postrst_wr", 1'b1, BASE + 32'h3000, 32'hCAFE_F00D, 0, 1'b0);
    xfer("postrst_rd", 1'b0, BASE + 32'h3000, 32'd0, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = BASE + ($urandom_range(0, NS - 1) << SH) + ($urandom_range(0, 15) << 2);
      else if (r == 8) a = BASE + (NS << SH) + ($urandom_range(0, 255) << 2);
      else             a = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      serr  = ($urandom_range(0, 7) == 0);
      xfer("rnd", bit'($urandom_range(0, 1)), a, $urandom, waits, serr);
    end

`ifdef APB_CMD_BUF_EN
    // A then B back to back; C arrives while B is buffered and must be dropped
    wait_cfg = 2;
    @(negedge PCLK);
    bus.transfer = 1'b1; bus.write = 1'b1; bus.addr = BASE; bus.wdata = 32'h1111;
    @(negedge PCLK);
    bus.addr = BASE + 32'h1000; bus.wdata = 32'h2222;
    @(negedge PCLK);
    chk("buf.busy_full", 32'(bus.busy), 32'd1);
    bus.addr = BASE + 32'h2000; bus.wdata = 32'h3333;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (bus.ready) begin
        lat = k;
        break;
      end
      @(negedge PCLK);
    end
    chk("buf.a_ready_seen", 32'(lat >= 0), 32'd1);
    chk("buf.b_setup_psel", 32'(bus.PSEL), 32'b0010);
    chk("buf.b_setup_penable", 32'(bus.PENABLE), 32'd0);
    nrdy = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (bus.ready) nrdy++;
    end
    chk("buf.one_more_ready", 32'(nrdy), 32'd1);
    ref_mem[0][0] = 32'h1111;
    ref_mem[1][0] = 32'h2222;
    wait_cfg = 0;
    xfer("buf.rd_s1", 1'b0, BASE + 32'h1000, 32'd0, 0, 1'b0);
    xfer("buf.rd_s2_untouched", 1'b0, BASE + 32'h2000, 32'd0, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
